// File: rtl/mano_icache_ctrl_pkg.sv
// Shared cache defaults and controller state encodings for the MANO cache slice.
// No logic; no latency or flow control of its own.
package mano_icache_ctrl_pkg;

  localparam int CACHE_ADDR_W = 12;
  localparam int CACHE_DATA_W = 16;
  localparam int CACHE_IDX_W  = 4;
  localparam int CACHE_CNT_W  = 16;

  localparam logic [1:0] CC_IDLE  = 2'd0;
  localparam logic [1:0] CC_FILL  = 2'd1;
  localparam logic [1:0] CC_WRITE = 2'd2;
  localparam logic [1:0] CC_FLUSH = 2'd3;

endpackage

// File: rtl/mano_icache_ctrl_line_ram.sv
// Tag+data line store: combinational read, write on the rising edge.
// No flow control; the controller owns valid bits and arbitration.
module cache_line_ram #(
  parameter int IDX_W  = 4,
  parameter int LINE_W = 24
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [IDX_W-1:0]  i_waddr,
  input  logic [LINE_W-1:0] i_wdat,
  input  logic [IDX_W-1:0]  i_raddr,
  output logic [LINE_W-1:0] o_rdat
);

  logic [LINE_W-1:0] r_mem [1<<IDX_W];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdat;
    end
  end

  assign o_rdat = r_mem[i_raddr];

endmodule

// File: rtl/mano_icache_ctrl.sv
// Direct-mapped write-through, no-write-allocate cache: read hits ack in the same cycle,
// misses and writes hold the requester until the memory-side mem_ack completes.
module mano_icache_ctrl
  import mano_icache_ctrl_pkg::*;
#(
  parameter int ADDR_W = CACHE_ADDR_W,
  parameter int DATA_W = CACHE_DATA_W,
  parameter int IDX_W  = CACHE_IDX_W,
  parameter int CNT_W  = CACHE_CNT_W
) (
  input  logic              mclk,
  input  logic              mrst,
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cache_hit,
  input  logic              flush,
  output logic              flush_busy,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt
);

  localparam int TAG_W  = ADDR_W - IDX_W;
  localparam int LINE_W = TAG_W + DATA_W;
  localparam int LINES  = 1 << IDX_W;

  logic [1:0]        r_state;
  logic [LINES-1:0]  r_valid;
  logic [IDX_W-1:0]  r_flush_idx;
  logic              r_flush_pending;
  logic              r_mem_rd;
  logic              r_mem_wr;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [CNT_W-1:0]  r_hit_cnt;
  logic [CNT_W-1:0]  r_miss_cnt;

  logic [IDX_W-1:0]  w_idx;
  logic [TAG_W-1:0]  w_tag;
  logic [LINE_W-1:0] w_line;
  logic              w_hit;
  logic              w_idle;
  logic              w_flush_go;
  logic              w_rd_hit;
  logic              w_wr_req;
  logic              w_fill_done;
  logic              w_wr_done;
  logic              w_ram_we;
  logic [IDX_W-1:0]  w_ram_waddr;
  logic [LINE_W-1:0] w_ram_wdat;

  assign w_idx  = cpu_addr[IDX_W-1:0];
  assign w_tag  = cpu_addr[ADDR_W-1:IDX_W];
  assign w_hit  = r_valid[w_idx] && (w_line[LINE_W-1:DATA_W] == w_tag);
  assign w_idle = (r_state == CC_IDLE);

  // A new or pending flush wins over any request presented in the same IDLE cycle.
  assign w_flush_go  = flush || r_flush_pending;
  assign w_rd_hit    = mrst && w_idle && !w_flush_go && cpu_rd && !cpu_wr && w_hit;
  assign w_wr_req    = mrst && w_idle && !w_flush_go && cpu_wr;
  assign w_fill_done = mrst && (r_state == CC_FILL) && mem_ack;
  assign w_wr_done   = mrst && (r_state == CC_WRITE) && mem_ack;

  assign cache_hit  = w_rd_hit || w_wr_done;
  assign cpu_rdata  = w_rd_hit ? w_line[DATA_W-1:0] : '0;
  assign flush_busy = (r_state == CC_FLUSH);
  assign mem_rd     = r_mem_rd;
  assign mem_wr     = r_mem_wr;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign hit_cnt    = r_hit_cnt;
  assign miss_cnt   = r_miss_cnt;

  // Fills install tag+data; write hits refresh data under the existing tag.
  assign w_ram_we    = w_fill_done || (w_wr_req && w_hit);
  assign w_ram_waddr = w_fill_done ? r_mem_addr[IDX_W-1:0] : w_idx;
  assign w_ram_wdat  = w_fill_done ? {r_mem_addr[ADDR_W-1:IDX_W], mem_rdata}
                                   : {w_tag, cpu_wdata};

  cache_line_ram #(
    .IDX_W  (IDX_W),
    .LINE_W (LINE_W)
  ) u_line_ram (
    .i_clk   (mclk),
    .i_we    (w_ram_we),
    .i_waddr (w_ram_waddr),
    .i_wdat  (w_ram_wdat),
    .i_raddr (w_idx),
    .o_rdat  (w_line)
  );

  always_ff @(posedge mclk) begin
    if (!mrst) begin
      r_state         <= CC_IDLE;
      r_valid         <= '0;
      r_flush_idx     <= '0;
      r_flush_pending <= 1'b0;
      r_mem_rd        <= 1'b0;
      r_mem_wr        <= 1'b0;
      r_mem_addr      <= '0;
      r_mem_wdata     <= '0;
      r_hit_cnt       <= '0;
      r_miss_cnt      <= '0;
    end else begin
      case (r_state)
        CC_IDLE: begin
          if (w_flush_go) begin
            r_state         <= CC_FLUSH;
            r_flush_idx     <= '0;
            r_flush_pending <= 1'b0;
          end else if (cpu_wr) begin
            r_mem_addr  <= cpu_addr;
            r_mem_wdata <= cpu_wdata;
            r_mem_wr    <= 1'b1;
            r_state     <= CC_WRITE;
          end else if (cpu_rd) begin
            if (w_hit) begin
              if (r_hit_cnt != '1) begin
                r_hit_cnt <= r_hit_cnt + CNT_W'(1);
              end
            end else begin
              r_mem_addr <= cpu_addr;
              r_mem_rd   <= 1'b1;
              r_state    <= CC_FILL;
              if (r_miss_cnt != '1) begin
                r_miss_cnt <= r_miss_cnt + CNT_W'(1);
              end
            end
          end
        end
        CC_FILL: begin
          if (flush) begin
            r_flush_pending <= 1'b1;
          end
          if (mem_ack) begin
            r_valid[r_mem_addr[IDX_W-1:0]] <= 1'b1;
            r_mem_rd <= 1'b0;
            r_state  <= CC_IDLE;
          end
        end
        CC_WRITE: begin
          if (flush) begin
            r_flush_pending <= 1'b1;
          end
          if (mem_ack) begin
            r_mem_wr <= 1'b0;
            r_state  <= CC_IDLE;
          end
        end
        CC_FLUSH: begin
          r_valid[r_flush_idx] <= 1'b0;
          r_flush_idx          <= r_flush_idx + IDX_W'(1);
          if (r_flush_idx == {IDX_W{1'b1}}) begin
            r_state <= CC_IDLE;
          end
        end
        default: r_state <= CC_IDLE;
      endcase
    end
  end

endmodule
